// File: rtl/count_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : count_reporter
//  Description : Snapshots two counter values on a request and streams them
//                out as a framed byte sequence over a valid/ready handshake:
//                HEADER, Count0 bytes (MSB first), Count1 bytes (MSB first),
//                and optionally an XOR checksum byte.
//                The counters keep running while the frozen snapshot drains.
//
//  Optional feature macro:
//    COUNT_REPORTER_CSUM_EN - append a running XOR over HEADER and all payload
//                             bytes as the final frame byte.
//
//  Ports:
//    Clk      in   1      clock, rising edge
//    Reset    in   1      asynchronous active-low reset
//    Count0   in   CNT_W  channel-0 count
//    Count1   in   CNT_W  channel-1 count
//    Req      in   1      snapshot request
//    TxData   out  8      current frame byte
//    TxValid  out  1      TxData valid
//    TxReady  in   1      sink accepts TxData this cycle
//    Busy     out  1      frame in progress
//    Dropped  out  8      saturating count of ignored requests
//
//  Revision    : 1.0 - initial release
// ============================================================================
module count_reporter #(
    parameter int          CNT_W  = 64,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [CNT_W-1:0] Count0,
    input  logic [CNT_W-1:0] Count1,
    input  logic             Req,
    output logic [7:0]       TxData,
    output logic             TxValid,
    input  logic             TxReady,
    output logic             Busy,
    output logic [7:0]       Dropped
);

    localparam int c_N     = CNT_W / 8;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_SEND0 = 3'd2,
`ifdef COUNT_REPORTER_CSUM_EN
        S_SEND1 = 3'd3,
        S_CSUM  = 3'd4
`else
        S_SEND1 = 3'd3
`endif
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_shadow0;
    logic [CNT_W-1:0]     r_shadow1;
    logic [c_IDX_W-1:0]   r_idx;
    logic [7:0]           r_dropped;
    logic                 w_hs;
    logic                 w_last;
`ifdef COUNT_REPORTER_CSUM_EN
    logic [7:0]           r_csum;
`endif

    assign w_hs    = TxValid & TxReady;
    assign w_last  = (r_idx == c_LAST);
    assign Busy    = (r_state != S_IDLE);
    assign Dropped = r_dropped;

    // Next-state and output decode. Outputs depend only on registered state,
    // so TxData/TxValid are stable until the handshake moves the state.
    always_comb begin
        w_next  = r_state;
        TxData  = 8'h00;
        TxValid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Req) w_next = S_HDR;
            end
            S_HDR: begin
                TxData  = HEADER;
                TxValid = 1'b1;
                if (TxReady) w_next = S_SEND0;
            end
            S_SEND0: begin
                TxData  = r_shadow0[CNT_W-1 -: 8];
                TxValid = 1'b1;
                if (TxReady && w_last) w_next = S_SEND1;
            end
            S_SEND1: begin
                TxData  = r_shadow1[CNT_W-1 -: 8];
                TxValid = 1'b1;
`ifdef COUNT_REPORTER_CSUM_EN
                if (TxReady && w_last) w_next = S_CSUM;
`else
                if (TxReady && w_last) w_next = S_IDLE;
`endif
            end
`ifdef COUNT_REPORTER_CSUM_EN
            S_CSUM: begin
                TxData  = r_csum;
                TxValid = 1'b1;
                if (TxReady) w_next = S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Shadows shift left on each accepted payload byte so the byte on the
    // wire is always the top byte; the index only counts bytes per channel.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_shadow0 <= '0;
            r_shadow1 <= '0;
            r_idx     <= '0;
            r_dropped <= 8'h00;
`ifdef COUNT_REPORTER_CSUM_EN
            r_csum    <= 8'h00;
`endif
        end else begin
            r_state <= w_next;

            // Any request seen outside IDLE is dropped, including the one on
            // the edge that completes the last byte.
            if (Req && (r_state != S_IDLE) && (r_dropped != 8'hFF))
                r_dropped <= r_dropped + 8'd1;

            case (r_state)
                S_IDLE: begin
                    if (Req) begin
                        r_shadow0 <= Count0;
                        r_shadow1 <= Count1;
                        r_idx     <= '0;
                    end
                end
                S_HDR: begin
`ifdef COUNT_REPORTER_CSUM_EN
                    if (w_hs) r_csum <= HEADER;
`endif
                end
                S_SEND0: begin
                    if (w_hs) begin
                        r_shadow0 <= r_shadow0 << 8;
                        r_idx     <= w_last ? '0 : r_idx + 1'b1;
`ifdef COUNT_REPORTER_CSUM_EN
                        r_csum    <= r_csum ^ r_shadow0[CNT_W-1 -: 8];
`endif
                    end
                end
                S_SEND1: begin
                    if (w_hs) begin
                        r_shadow1 <= r_shadow1 << 8;
                        r_idx     <= w_last ? '0 : r_idx + 1'b1;
`ifdef COUNT_REPORTER_CSUM_EN
                        r_csum    <= r_csum ^ r_shadow1[CNT_W-1 -: 8];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_reporter
//  Description : Self-checking bench for count_reporter. Expected frames are
//                built from the counter values as a byte list; drop counts
//                are tracked as a saturating integer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_reporter;

    localparam int         CNT_W  = 64;
    localparam int         N      = CNT_W / 8;
    localparam logic [7:0] HEADER = 8'hA5;

    logic             Clk;
    logic             Reset;
    logic [CNT_W-1:0] Count0;
    logic [CNT_W-1:0] Count1;
    logic             Req;
    logic [7:0]       TxData;
    logic             TxValid;
    logic             TxReady;
    logic             Busy;
    logic [7:0]       Dropped;

    int         checks;
    int         errors;
    int         exp_dropped;
    logic [7:0] exp_q[$];

    count_reporter #(.CNT_W(CNT_W), .HEADER(HEADER)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Count0  (Count0),
        .Count1  (Count1),
        .Req     (Req),
        .TxData  (TxData),
        .TxValid (TxValid),
        .TxReady (TxReady),
        .Busy    (Busy),
        .Dropped (Dropped)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one clock; inputs change and outputs are sampled 1 after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic bump_dropped();
        if (exp_dropped < 255) exp_dropped++;
    endtask

    // Expected frame: header, Count0 MSB-first, Count1 MSB-first, [xor].
    task automatic build_expected(input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1);
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(HEADER);
        for (int i = N - 1; i >= 0; i--) exp_q.push_back(8'((c0 >> (8 * i)) & 64'hFF));
        for (int i = N - 1; i >= 0; i--) exp_q.push_back(8'((c1 >> (8 * i)) & 64'hFF));
`ifdef COUNT_REPORTER_CSUM_EN
        x = 8'h00;
        foreach (exp_q[k]) x = x ^ exp_q[k];
        exp_q.push_back(x);
`else
        x = 8'h00;
`endif
    endtask

    task automatic start_frame(input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1);
        Count0 = c0;
        Count1 = c1;
        build_expected(c0, c1);
        Req = 1'b1;
        step();
        Req = 1'b0;
        checks++;
        if ({Busy, TxValid, TxData} !== {1'b1, 1'b1, HEADER}) begin
            errors++;
            $display("FAIL start_latency: busy=%b valid=%b data=%h, required 1 1 %h",
                     Busy, TxValid, TxData, HEADER);
        end
    endtask

    // mode 0: ready always, 1: ready toggling 1/0, 2: random ready.
    task automatic drain_frame(input int mode, input int drop_reqs, input bit last_req,
                               input bit change_counts, output int cycles);
        int  idx;
        bit  ready;
        bit  req;
        idx    = 0;
        cycles = 0;
        while (idx < exp_q.size() && cycles < 500) begin
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (cycles % 2 == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            req = 1'b0;
            if (drop_reqs > 0 && (cycles % 2 == 1) && (cycles / 2 < drop_reqs)) req = 1'b1;
            if (last_req && ready && idx == exp_q.size() - 1) req = 1'b1;
            TxReady = ready;
            Req     = req;
            if (req) bump_dropped();
            if (change_counts && cycles == 0) begin
                Count0 = '1;
                Count1 = {$urandom, $urandom};
            end
            checks++;
            if ({Busy, TxValid, TxData} !== {1'b1, 1'b1, exp_q[idx]}) begin
                errors++;
                $display("FAIL frame_byte[%0d] cyc %0d: busy=%b valid=%b data=%h, required 1 1 %h",
                         idx, cycles, Busy, TxValid, TxData, exp_q[idx]);
            end
            if (ready) idx++;
            step();
            cycles++;
        end
        TxReady = 1'b0;
        Req     = 1'b0;
        if (idx < exp_q.size()) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: accepted %0d bytes, required %0d", idx, exp_q.size());
        end
        checks++;
        if ({Busy, TxValid, TxData, Dropped} !== {1'b0, 1'b0, 8'h00, 8'(exp_dropped)}) begin
            errors++;
            $display("FAIL frame_end: busy=%b valid=%b data=%h dropped=%0d, required 0 0 00 %0d",
                     Busy, TxValid, TxData, Dropped, exp_dropped);
        end
    endtask

    task automatic test_reset();
        Reset   = 1'b0;
        Req     = 1'b0;
        TxReady = 1'b0;
        Count0  = '0;
        Count1  = '0;
        exp_dropped = 0;
        repeat (3) step();
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            Count0 = {$urandom, $urandom};
            TxReady = 1'($urandom_range(0, 1));
            step();
            checks++;
            if ({TxValid, Busy, Dropped, TxData} !== {1'b0, 1'b0, 8'h00, 8'h00}) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: valid=%b busy=%b dropped=%h data=%h, required 0 0 00 00",
                         i, TxValid, Busy, Dropped, TxData);
            end
        end
        TxReady = 1'b0;
    endtask

    task automatic test_basic_frame();
        int cyc;
        start_frame(64'h5, 64'h3);
        drain_frame(0, 0, 1'b0, 1'b0, cyc);
        checks++;
        if (cyc !== exp_q.size()) begin
            errors++;
            $display("FAIL basic_length: %0d cycles, required %0d", cyc, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        start_frame(64'h5, 64'h3);
        drain_frame(1, 0, 1'b0, 1'b0, cyc);
        checks++;
        if (cyc !== 2 * exp_q.size() - 1) begin
            errors++;
            $display("FAIL toggle_length: %0d cycles, required %0d", cyc, 2 * exp_q.size() - 1);
        end
    endtask

    task automatic test_shadow_and_drop();
        int cyc;
        start_frame(64'h5, 64'h3);
        drain_frame(0, 3, 1'b0, 1'b1, cyc);
        checks++;
        if (Dropped !== 8'd3) begin
            errors++;
            $display("FAIL drop_three: dropped=%0d, required 3", Dropped);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_frame({$urandom, $urandom}, {$urandom, $urandom});
        drain_frame(0, 0, 1'b1, 1'b0, cyc);
        // Request on the very next edge must start a fresh frame.
        start_frame({$urandom, $urandom}, {$urandom, $urandom});
        drain_frame(2, 0, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_saturate();
        int cyc;
        start_frame(64'h1234_5678_9ABC_DEF0, 64'h0F0E_0D0C_0B0A_0908);
        TxReady = 1'b0;
        Req     = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bump_dropped();
            step();
        end
        Req = 1'b0;
        checks++;
        if ({Dropped, TxValid, TxData} !== {8'hFF, 1'b1, HEADER}) begin
            errors++;
            $display("FAIL drop_saturate: dropped=%h valid=%b data=%h, required FF 1 %h",
                     Dropped, TxValid, TxData, HEADER);
        end
        drain_frame(2, 2, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        start_frame({$urandom, $urandom}, {$urandom, $urandom});
        TxReady = 1'b1;
        repeat (1 + N + 4) step();   // header + Count0 + 4 bytes of Count1
        TxReady = 1'b0;
        checks++;
        if ({TxValid, TxData} !== {1'b1, exp_q[1 + N + 4]}) begin
            errors++;
            $display("FAIL pre_abort_byte: valid=%b data=%h, required 1 %h",
                     TxValid, TxData, exp_q[1 + N + 4]);
        end
        #2;
        Reset = 1'b0;
        exp_dropped = 0;
        #1;
        checks++;
        if ({TxValid, Busy, Dropped, TxData} !== {1'b0, 1'b0, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL async_reset: valid=%b busy=%b dropped=%h data=%h, required 0 0 00 00",
                     TxValid, Busy, Dropped, TxData);
        end
        step();
        Reset = 1'b1;
        step();
        checks++;
        if ({TxValid, Busy} !== 2'b00) begin
            errors++;
            $display("FAIL no_resume: valid=%b busy=%b, required 0 0", TxValid, Busy);
        end
        start_frame({$urandom, $urandom}, {$urandom, $urandom});
        drain_frame(0, 0, 1'b0, 1'b0, cyc);
    endtask

    task automatic test_random();
        int cyc;
        for (int f = 0; f < 6; f++) begin
            start_frame({$urandom, $urandom}, {$urandom, $urandom});
            drain_frame(2, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b1, cyc);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_shadow_and_drop();
        test_back_to_back();
        test_saturate();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
